// File: rtl/seg7_pkg.sv
// Shared types, constants and segment table for the 4-digit seven-segment scan driver.
package seg7_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam int unsigned BIN_W = 14;
    localparam int unsigned BCD_W = 16;

    localparam logic [BIN_W-1:0] MAX_DISPLAY = 14'd9999;

    // Segment order {g,f,e,d,c,b,a}, active low
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_PATTERN [0:9] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    typedef enum logic [1:0] {StIdle, StShift, StDone} conv_state_t;

    function automatic logic [6:0] seg_decode(input bcd_digit_t d);
        if (d > 4'd9) begin
            return SEG_PATTERN[0];
        end
        return SEG_PATTERN[d];
    endfunction

endpackage

// File: rtl/seg7_scan_driver_bin2bcd_seq.sv
// Sequential double-dabble converter: one shift per cycle, start/busy/done handshake.
module bin2bcd_seq
    import seg7_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [BIN_W-1:0] bin,
    output logic             busy,
    output logic             done,
    output logic [BCD_W-1:0] bcd
);

    localparam int unsigned SR_W = BIN_W + BCD_W;

    conv_state_t     state_q;
    logic [SR_W-1:0] sr_q;
    logic [3:0]      cnt_q;

    // Add-3 on every BCD nibble >= 5, then shift the whole register left by one.
    function automatic logic [SR_W-1:0] dabble_step(input logic [SR_W-1:0] s);
        logic [SR_W-1:0] t;
        t = s;
        for (int i = 0; i < BCD_W / 4; i++) begin
            if (t[BIN_W + 4*i +: 4] >= 4'd5) begin
                t[BIN_W + 4*i +: 4] = t[BIN_W + 4*i +: 4] + 4'd3;
            end
        end
        return {t[SR_W-2:0], 1'b0};
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            sr_q    <= '0;
            cnt_q   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        sr_q    <= {{BCD_W{1'b0}}, bin};
                        cnt_q   <= '0;
                        busy    <= 1'b1;
                        state_q <= StShift;
                    end
                end
                StShift: begin
                    sr_q  <= dabble_step(sr_q);
                    cnt_q <= cnt_q + 4'd1;
                    if (cnt_q == 4'(BIN_W - 1)) begin
                        done    <= 1'b1;
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bcd = sr_q[SR_W-1 -: BCD_W];

endmodule

// File: rtl/seg7_scan_driver.sv
// Binary-to-BCD display back end with time-multiplexed common-anode scan.
// Optional macro LEADING_ZERO_BLANK_EN blanks digits above the most significant non-zero digit.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned NUM_DIGITS  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [BIN_W-1:0]      res,
    input  logic                  load,
    output logic                  busy,
    output logic                  ovf,
    output logic [NUM_DIGITS-1:0] anode,
    output logic [6:0]            cathode,
    output logic                  dp
);

    localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned IDX_W = $clog2(NUM_DIGITS);

    logic                    conv_done;
    logic [BCD_W-1:0]        conv_bcd;
    logic [4*NUM_DIGITS-1:0] disp_q;
    logic                    ovf_q;
    logic                    pend_ovf_q;
    logic [CNT_W-1:0]        ref_q;
    logic [IDX_W-1:0]        idx_q;
    bcd_digit_t              digit;
    logic [NUM_DIGITS-1:0]   anode_d;
    logic [6:0]              cathode_d;

    bin2bcd_seq u_conv (
        .clk   (clk),
        .rst   (rst),
        .start (load),
        .bin   (res),
        .busy  (busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    // Displayed value only changes in DONE, so a scan pass never sees a partial result.
    always_ff @(posedge clk) begin
        if (rst) begin
            disp_q     <= '0;
            ovf_q      <= 1'b0;
            pend_ovf_q <= 1'b0;
        end else begin
            if (load && !busy) begin
                pend_ovf_q <= (res > MAX_DISPLAY);
            end
            if (conv_done) begin
                ovf_q  <= pend_ovf_q;
                disp_q <= pend_ovf_q ? '0 : conv_bcd;
            end
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic [IDX_W-1:0] msd;

    always_comb begin
        msd = '0;
        for (int i = 1; i < NUM_DIGITS; i++) begin
            if (disp_q[4*i +: 4] != 4'd0) begin
                msd = IDX_W'(i);
            end
        end
    end
`endif

    always_comb begin
        digit     = disp_q[{idx_q, 2'b00} +: 4];
        anode_d   = ~(NUM_DIGITS'(1) << idx_q);
        cathode_d = ovf_q ? SEG_DASH : seg_decode(digit);
`ifdef LEADING_ZERO_BLANK_EN
        if (!ovf_q && (idx_q > msd)) begin
            anode_d   = '1;
            cathode_d = SEG_BLANK;
        end
`else
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ref_q   <= '0;
            idx_q   <= '0;
            anode   <= '1;
            cathode <= SEG_BLANK;
        end else begin
            if (ref_q == CNT_W'(REFRESH_DIV - 1)) begin
                ref_q <= '0;
                idx_q <= (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
            end else begin
                ref_q <= ref_q + CNT_W'(1);
            end
            anode   <= anode_d;
            cathode <= cathode_d;
        end
    end

    assign ovf = ovf_q;
    assign dp  = 1'b1;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench: arithmetic display model compared every cycle plus literal spot checks.
module tb_seg7_scan_driver;

    localparam int RD = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [13:0] res = '0;
    logic        load = 1'b0;
    logic        busy;
    logic        ovf;
    logic [3:0]  anode;
    logic [6:0]  cathode;
    logic        dp;

    int errs   = 0;
    int checks = 0;

    seg7_scan_driver #(.REFRESH_DIV(RD)) dut (
        .clk     (clk),
        .rst     (rst),
        .res     (res),
        .load    (load),
        .busy    (busy),
        .ovf     (ovf),
        .anode   (anode),
        .cathode (cathode),
        .dp      (dp)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            default: return 7'b0010000;
        endcase
    endfunction

    function automatic int pow10(input int k);
        case (k)
            0: return 1;
            1: return 10;
            2: return 100;
            default: return 1000;
        endcase
    endfunction

    function automatic bit blanked(input int val, input bit o, input int slot);
`ifdef LEADING_ZERO_BLANK_EN
        return !o && slot > 0 && val < pow10(slot);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [6:0] exp_cath(input int val, input bit o, input int slot);
        if (o) return 7'b0111111;
        if (blanked(val, o, slot)) return 7'b1111111;
        return seg_of((val / pow10(slot)) % 10);
    endfunction

    function automatic logic [3:0] exp_anode(input int val, input bit o, input int slot);
        logic [3:0] a;
        a = 4'b1111;
        if (!blanked(val, o, slot)) a[slot] = 1'b0;
        return a;
    endfunction

    // Model: what the pins must show, derived from value, overflow flag and time since reset.
    bit         m_valid = 1'b0;
    int         m_t, m_busy, m_pend, m_val;
    bit         m_ovf;
    logic [3:0] m_anode;
    logic [6:0] m_cath;

    always @(posedge clk) begin
        if (rst) begin
            m_valid <= 1'b1;
            m_t     <= 0;
            m_busy  <= 0;
            m_val   <= 0;
            m_ovf   <= 1'b0;
            m_anode <= 4'b1111;
            m_cath  <= 7'b1111111;
        end else begin
            m_t     <= m_t + 1;
            m_anode <= exp_anode(m_val, m_ovf, (m_t / RD) % 4);
            m_cath  <= exp_cath(m_val, m_ovf, (m_t / RD) % 4);
            if (m_busy == 0) begin
                if (load) begin
                    m_busy <= 15;
                    m_pend <= int'(res);
                end
            end else begin
                m_busy <= m_busy - 1;
                if (m_busy == 1) begin
                    m_ovf <= (m_pend > 9999);
                    m_val <= (m_pend > 9999) ? 0 : m_pend;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (m_valid) begin
                chk("anode", {28'd0, anode}, {28'd0, m_anode});
                chk("cathode", {25'd0, cathode}, {25'd0, m_cath});
                chk("busy", {31'd0, busy}, {31'd0, m_busy != 0});
                chk("ovf", {31'd0, ovf}, {31'd0, m_ovf});
                chk("dp", {31'd0, dp}, 32'd1);
            end
        end
    endtask

    task automatic start_load(input int v);
        @(negedge clk);
        res  = 14'(v);
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
        @(negedge clk);
    endtask

    task automatic see_digit(input string name, input logic [3:0] a, input logic [6:0] c);
        int n;
        n = 0;
        while (anode !== a && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_anode"}, {28'd0, anode}, {28'd0, a});
        chk(name, {25'd0, cathode}, {25'd0, c});
    endtask

    initial begin
        int n;
        fork
            monitor();
        join_none

        // Reset state and first lit digit
        repeat (3) @(negedge clk);
        chk("rst_anode", {28'd0, anode}, 32'hF);
        chk("rst_cathode", {25'd0, cathode}, 32'h7F);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("first_anode", {28'd0, anode}, 32'b1110);
        chk("first_cathode", {25'd0, cathode}, 32'b1000000);
        repeat (4 * 4 * RD) @(negedge clk);

        // 1234: busy length and one full scan
        start_load(1234);
        wait_idle(n);
        chk("busy_len", n, 15);
        see_digit("d1234_0", 4'b1110, 7'b0011001);
        see_digit("d1234_1", 4'b1101, 7'b0110000);
        see_digit("d1234_2", 4'b1011, 7'b0100100);
        see_digit("d1234_3", 4'b0111, 7'b1111001);

        // Overflow and range boundaries
        start_load(16383);
        wait_idle(n);
        chk("ovf_16383", {31'd0, ovf}, 32'd1);
        see_digit("dash_3", 4'b0111, 7'b0111111);
        start_load(9999);
        wait_idle(n);
        chk("ovf_9999", {31'd0, ovf}, 32'd0);
        see_digit("d9999_2", 4'b1011, 7'b0010000);
        start_load(10000);
        wait_idle(n);
        chk("ovf_10000", {31'd0, ovf}, 32'd1);
        repeat (4 * RD) @(negedge clk);

        // Load while busy is dropped
        start_load(42);
        @(negedge clk);
        res  = 14'd7000;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        wait_idle(n);
        see_digit("d42_0", 4'b1110, 7'b0100100);
        see_digit("d42_1", 4'b1101, 7'b0011001);
        repeat (4 * RD) @(negedge clk);

        // Reset mid-conversion
        start_load(500);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_ovf", {31'd0, ovf}, 32'd0);
        @(negedge clk);
        chk("abort_anode", {28'd0, anode}, 32'b1110);
        chk("abort_cathode", {25'd0, cathode}, 32'b1000000);
        repeat (4 * RD) @(negedge clk);

`ifdef LEADING_ZERO_BLANK_EN
        start_load(7);
        wait_idle(n);
        for (int i = 0; i < 4 * RD; i++) begin
            chk("lz7_anode", {31'd0, (anode == 4'b1110) || (anode == 4'b1111)}, 32'd1);
            if (anode == 4'b1110) chk("lz7_cathode", {25'd0, cathode}, 32'b1111000);
            @(negedge clk);
        end
        start_load(0);
        wait_idle(n);
        see_digit("lz0_0", 4'b1110, 7'b1000000);
        repeat (4 * RD) @(negedge clk);
`else
        start_load(7);
        wait_idle(n);
        see_digit("d7_3", 4'b0111, 7'b1000000);
        see_digit("d7_0", 4'b1110, 7'b1111000);
`endif

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
